// File: rtl/pam8_rx_demod.sv
`default_nettype none
// ============================================================================
// Module   : pam8_rx_demod
// Purpose  : PAM-8 receiver demodulator for 4x-oversampled shaped samples.
//            Acquisition picks the sampling phase with the largest summed
//            magnitude over ACQ_SYMS symbols. Tracking then slices one
//            sample per symbol on that phase into {-7..7 odd} plus an error.
// Ports    : clk        rising-edge clock
//            nrst       asynchronous active-low reset
//            sample_in  signed 16-bit input samples
//            in_valid   sample_in valid strobe
//            restart    one-cycle pulse that forces re-acquisition
//            sym        signed decided symbol
//            sym_err    signed error, sample minus sym*UNIT (17 bit)
//            sym_valid  one-cycle strobe for sym/sym_err
//            locked     high while tracking
//            sel_phase  sampling phase chosen by acquisition
// Revision : 1.0 - initial release
// ============================================================================
module pam8_rx_demod #(
  parameter int UNIT     = 274,
  parameter int ACQ_SYMS = 64
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic signed [15:0] sample_in,
  input  logic               in_valid,
  input  logic               restart,
  output logic signed [3:0]  sym,
  output logic signed [16:0] sym_err,
  output logic               sym_valid,
  output logic               locked,
  output logic [1:0]         sel_phase
);

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_DECIDE = 2'd1,
    ST_TRACK  = 2'd2
  } state_t;

  localparam logic [7:0]         LAST_SYM = 8'(ACQ_SYMS - 1);
  localparam logic signed [16:0] T2 = 17'(2 * UNIT);
  localparam logic signed [16:0] T4 = 17'(4 * UNIT);
  localparam logic signed [16:0] T6 = 17'(6 * UNIT);
  localparam logic signed [16:0] L1 = 17'(UNIT);
  localparam logic signed [16:0] L3 = 17'(3 * UNIT);
  localparam logic signed [16:0] L5 = 17'(5 * UNIT);
  localparam logic signed [16:0] L7 = 17'(7 * UNIT);

  state_t             state;
  logic [1:0]         phase;
  logic [7:0]         sym_cnt;
  logic [24:0]        energy [4];
  logic signed [15:0] s1_x;
  logic               s1_valid;

  // |sample_in| in 17 bits so that -32768 maps to 32768 without overflow.
  logic [16:0] mag;
  always_comb begin
    mag = {1'b0, sample_in};
    if (sample_in[15]) mag = ~{1'b1, sample_in} + 17'd1;
  end

  // Largest accumulator; strict compare keeps the lowest index on ties.
  logic [1:0]  best_idx;
  logic [24:0] best_val;
  always_comb begin
    best_idx = 2'd0;
    best_val = energy[0];
    for (int i = 1; i < 4; i++) begin
      if (energy[i] > best_val) begin
        best_val = energy[i];
        best_idx = 2'(i);
      end
    end
  end

  // Slicer on the stage-1 sample; thresholds decide upward when x >= T.
  logic signed [16:0] x_ext;
  logic signed [3:0]  dec;
  logic signed [16:0] lvl;
  always_comb begin
    x_ext = {s1_x[15], s1_x};
    if      (x_ext >=  T6) begin dec =  4'sd7; lvl =  L7; end
    else if (x_ext >=  T4) begin dec =  4'sd5; lvl =  L5; end
    else if (x_ext >=  T2) begin dec =  4'sd3; lvl =  L3; end
    else if (x_ext >= 17'sd0) begin dec = 4'sd1; lvl = L1; end
    else if (x_ext >= -T2) begin dec = -4'sd1; lvl = -L1; end
    else if (x_ext >= -T4) begin dec = -4'sd3; lvl = -L3; end
    else if (x_ext >= -T6) begin dec = -4'sd5; lvl = -L5; end
    else                   begin dec = -4'sd7; lvl = -L7; end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_ACQ;
      phase     <= 2'd0;
      sym_cnt   <= 8'd0;
      for (int i = 0; i < 4; i++) energy[i] <= 25'd0;
      s1_x      <= 16'sd0;
      s1_valid  <= 1'b0;
      sym       <= 4'sd0;
      sym_err   <= 17'sd0;
      sym_valid <= 1'b0;
      locked    <= 1'b0;
      sel_phase <= 2'd0;
    end else if (restart) begin
      // Drops the current sample and any stage-1 sample still in flight.
      state     <= ST_ACQ;
      phase     <= 2'd0;
      sym_cnt   <= 8'd0;
      for (int i = 0; i < 4; i++) energy[i] <= 25'd0;
      s1_valid  <= 1'b0;
      sym_valid <= 1'b0;
      locked    <= 1'b0;
    end else begin
      if (in_valid) phase <= phase + 2'd1;

      sym_valid <= s1_valid;
      if (s1_valid) begin
        sym     <= dec;
        sym_err <= x_ext - lvl;
      end

      s1_valid <= 1'b0;
      case (state)
        ST_ACQ: begin
          if (in_valid) begin
            energy[phase] <= energy[phase] + {8'd0, mag};
            if (phase == 2'd3) begin
              if (sym_cnt == LAST_SYM) begin
                sym_cnt <= 8'd0;
                state   <= ST_DECIDE;
              end else begin
                sym_cnt <= sym_cnt + 8'd1;
              end
            end
          end
        end
        ST_DECIDE: begin
          sel_phase <= best_idx;
          locked    <= 1'b1;
          state     <= ST_TRACK;
        end
        ST_TRACK: begin
          if (in_valid && (phase == sel_phase)) begin
            s1_x     <= sample_in;
            s1_valid <= 1'b1;
          end
        end
        default: state <= ST_ACQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pam8_rx_demod.md
PAM8_RX_DEMOD -- requirements
Module: pam8_rx_demod

Interface
REQ-001 Parameter UNIT, default 274: signed sample amplitude of one PAM unit; ideal levels are (2k+1)*UNIT.
REQ-002 Parameter ACQ_SYMS, default 64: symbol periods (groups of 4 valid samples) accumulated during acquisition; power of two, 2..256.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 nrst  input  1  reset; asynchronous, active-low.
REQ-005 sample_in  input  16  signed, 4x-oversampled shaped PAM-8 samples.
REQ-006 in_valid  input  1  sample_in is valid this cycle.
REQ-007 restart  input  1  one-cycle pulse that forces re-acquisition.
REQ-008 sym  output  4  signed decided symbol in {-7,-5,-3,-1,1,3,5,7}.
REQ-009 sym_err  output  17  signed error: sampled value minus sym*UNIT.
REQ-010 sym_valid  output  1  sym and sym_err are valid this cycle.
REQ-011 locked  output  1  high while in TRACK.
REQ-012 sel_phase  output  2  sampling phase chosen by acquisition.

Function
REQ-013 The block shall keep a 2-bit phase counter that increments modulo 4 on every accepted sample (in_valid=1) and holds when in_valid=0.
REQ-014 The FSM shall have the states ACQ, DECIDE and TRACK, and shall enter ACQ after reset and after restart.
REQ-015 In ACQ, each accepted sample's |sample_in| (17-bit unsigned, |-32768|=32768) shall be added to the 25-bit unsigned accumulator E[phase]; accumulators shall not wrap.
REQ-016 A symbol counter shall increment on each accepted sample with phase=3; ACQ shall exit to DECIDE on the accepted sample with phase=3 and symbol count=ACQ_SYMS-1 (4*ACQ_SYMS samples in total, the last one included).
REQ-017 DECIDE shall last exactly one cycle and shall set sel_phase to the index of the largest E, with ties going to the lowest index; accepted samples in this cycle shall advance the phase counter but shall not be used.
REQ-018 TRACK shall slice only the accepted samples whose phase equals sel_phase; all other samples shall be discarded.
REQ-019 Pipeline: stage 1 shall register the sample at accepting edge E, and stage 2 shall register sym, sym_err and sym_valid=1 at edge E+1; sym_valid shall be high for exactly one cycle per sliced sample.
REQ-020 Slicer thresholds shall be 0, ±2*UNIT, ±4*UNIT and ±6*UNIT, with x>=T deciding upward: x>=6U->7; 4U<=x<6U->5; 2U<=x<4U->3; 0<=x<2U->1; -2U<=x<0->-1; -4U<=x<-2U->-3; -6U<=x<-4U->-5; x<-6U->-7.
REQ-021 sym_err = x - sym*UNIT shall be computed in 17-bit signed arithmetic without saturation.
REQ-022 When sym_valid=0, sym and sym_err shall hold their last values.
REQ-023 restart in any state shall, at that edge, clear E, the symbol counter and the phase counter, enter ACQ, drop locked, and discard any sample presented in the same cycle; a restart shall also cancel a stage-1 sample that is in flight, so no sym_valid is issued for it.
REQ-024 locked shall be registered and shall be 1 exactly when the state is TRACK; sel_phase shall hold its value through ACQ until the next DECIDE.

Reset
REQ-025 While nrst=0: sym=0, sym_err=0, sym_valid=0, locked=0, sel_phase=0, state=ACQ, and all counters, accumulators and pipeline registers shall be 0.
REQ-026 Deassertion of nrst shall take effect at the next clk edge; the first accepted sample after reset shall have phase 0.

Verification
REQ-027 Reset: assert nrst=0 mid-TRACK -> all outputs 0 immediately, without waiting for a clk edge; locked=0.
REQ-028 Acquisition: UNIT=274, ACQ_SYMS=64; phase 2 carries ±1918 and the other phases ±100, for 256 continuous valid samples -> DECIDE, then locked=1, sel_phase=2; afterwards only phase-2 samples produce sym_valid, two edges after acceptance.
REQ-029 Slicer boundaries in TRACK: 548->(3,-274); 547->(1,273); 0->(1,-274); -1->(-1,273); 32767->(7,30849); -32768->(-7,-30850).
REQ-030 Tie: identical magnitudes on all four phases during acquisition -> sel_phase=0.
REQ-031 Gaps: in_valid randomly low 50% of cycles -> phase alignment and decisions identical to the gap-free run; 256 accepted samples are still required to lock.
REQ-032 restart: a restart pulse in TRACK coinciding with in_valid on sel_phase -> locked=0 next cycle, no sym_valid for that sample or for the in-flight sample, and relock only after 256 further accepted samples.
